// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional build macro: BIN_TO_BCD_SAT_EN (saturate bcd_out to all nines on overflow).
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must hold the value BIN_W itself, hence the +1.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/ready request and result bus of the binary-to-BCD converter.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);

  logic                          start;
  logic [BIN_W-1:0]              bin_in;
  logic                          ready;
  logic                          busy;
  logic                          valid;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
  logic                          overflow;

  modport master (
    output start, bin_in,
    input  ready, busy, valid, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output ready, busy, valid, bcd_out, overflow
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Single BCD digit correction cell: adds 3 to a digit holding 5..9 so the
// following left shift carries into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // Conditional +3 adjustment of one digit.
  always_comb begin
    o_digit = i_digit;
    if ((i_digit >= 4'd5) && (i_digit <= 4'd9)) begin
      o_digit = i_digit + 4'd3;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One iteration per clock; result and overflow flag appear with a one-cycle
// valid pulse BIN_W+1 cycles after the accepting edge.
// Optional build macro: BIN_TO_BCD_SAT_EN -- when defined, an overflowing
// result is replaced by all nines; otherwise the modulo 10^DIGITS value is kept.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_acc;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_result;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_ovf_sticky;
  logic               r_overflow;
  logic               r_valid;
  logic               r_ready;
  logic               r_busy;
  logic               w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_last = (r_cnt == CNT_W'(1));

`ifdef BIN_TO_BCD_SAT_EN
  assign w_result = r_ovf_sticky ? {DIGITS{BCD_NINE}} : r_acc;
`else
  assign w_result = r_acc;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: accept in IDLE, iterate in SHIFT, single DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = SHIFT;
        else           w_next = IDLE;
      end
      SHIFT: begin
        if (w_last) w_next = DONE;
        else        w_next = SHIFT;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Shift/add-3 datapath: load on accept, one adjust-and-shift per SHIFT cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_bin        <= '0;
      r_acc        <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bin        <= bus.bin_in;
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
            r_cnt        <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          r_acc        <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin        <= r_bin << 1;
          // A bit leaving the top digit is a carry worth 10^DIGITS.
          r_ovf_sticky <= r_ovf_sticky | w_adj[BCD_W-1];
          r_cnt        <= r_cnt - CNT_W'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Registered handshake and result outputs; results latch only on leaving DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_bcd_out  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ready <= (w_next == IDLE);
      r_busy  <= (w_next != IDLE);
      if (r_state == DONE) begin
        r_valid    <= 1'b1;
        r_bcd_out  <= w_result;
        r_overflow <= r_ovf_sticky;
      end else begin
        r_valid    <= 1'b0;
      end
    end
  end

  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.valid    = r_valid;
  assign bus.bcd_out  = r_bcd_out;
  assign bus.overflow = r_overflow;

endmodule
